// File: rtl/aes_if.sv
// Handshake/data bundle for aes_iter_core: request side (master) and engine side (slave).
// AES_ABORT_EN adds the abort request line.
interface aes_if #(
  parameter int NR_MAX = 14
);
  localparam int KS_W = 128 * (NR_MAX + 1);

  logic            start;
  logic            mode;
  logic [1:0]      key_len;
  logic [127:0]    data_in;
  logic [KS_W-1:0] w;
  logic [127:0]    data_out;
  logic            busy;
  logic            done;
  logic            err;
`ifdef AES_ABORT_EN
  logic            abort;

  modport master (
    output start, mode, key_len, data_in, w, abort,
    input  data_out, busy, done, err
  );

  modport slave (
    input  start, mode, key_len, data_in, w, abort,
    output data_out, busy, done, err
  );
`else
  modport master (
    output start, mode, key_len, data_in, w,
    input  data_out, busy, done, err
  );

  modport slave (
    input  start, mode, key_len, data_in, w,
    output data_out, busy, done, err
  );
`endif
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encrypt/decrypt engine, one round per clock, pre-expanded schedule.
// Optional AES_ABORT_EN adds an abort input that cancels a running operation.
module aes_iter_core #(
  parameter int NR_MAX = 14
) (
  input logic  clk,
  input logic  rst_n,
  aes_if.slave bus
);
  localparam int KS_W = 128 * (NR_MAX + 1);
  localparam int RC_W = $clog2(NR_MAX + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    t = a;
    for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), a);
    return gf_mul(t, t);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // State bytes are column-major, byte k = row (k%4), column (k/4), byte 0 in the MSBs
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w_row = 0; w_row < 4; w_row++)
        r[127-8*(w_row+4*c) -: 8] = s[127-8*(w_row+4*((c+w_row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w_row = 0; w_row < 4; w_row++)
        r[127-8*(w_row+4*((c+w_row)%4)) -: 8] = s[127-8*(w_row+4*c) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

  function automatic logic [127:0] round_key(input logic [KS_W-1:0] ws, input logic [RC_W-1:0] idx);
    return ws[KS_W-1-128*int'(idx) -: 128];
  endfunction

  state_t          state_r, nxt_state_s;
  logic [RC_W-1:0] rc_r, nxt_rc_s;
  logic [RC_W-1:0] nr_r, nxt_nr_s;
  logic            mode_r, nxt_mode_s;
  logic [127:0]    st_r, nxt_st_s;
  logic [127:0]    data_out_r, nxt_data_out_s;
  logic            busy_r, nxt_busy_s;
  logic            done_r, nxt_done_s;
  logic            err_r, nxt_err_s;

  logic            abort_s;
  logic [RC_W-1:0] acc_nr_s;
  logic [127:0]    acc_st_s;
  logic [RC_W-1:0] rk_idx_s;
  logic [127:0]    rk_s;
  logic            last_s;
  logic [127:0]    enc_sr_s, dec_sb_s, dec_add_s;
  logic [127:0]    round_s;

`ifdef AES_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // Round count for the requested key length; the illegal code is rejected before use
  always_comb begin
    case (bus.key_len)
      2'b00:   acc_nr_s = RC_W'(10);
      2'b01:   acc_nr_s = RC_W'(12);
      2'b10:   acc_nr_s = RC_W'(14);
      default: acc_nr_s = RC_W'(10);
    endcase
  end

  // Initial AddRoundKey: rk(0) when encrypting, rk(Nr) when decrypting
  always_comb begin
    if (bus.mode) begin
      acc_st_s = bus.data_in ^ round_key(bus.w, acc_nr_s);
    end else begin
      acc_st_s = bus.data_in ^ round_key(bus.w, RC_W'(0));
    end
  end

  // One round of the enc path and the dec path, selected by the latched mode
  always_comb begin
    last_s    = (rc_r == nr_r);
    rk_idx_s  = mode_r ? (nr_r - rc_r) : rc_r;
    rk_s      = round_key(bus.w, rk_idx_s);
    enc_sr_s  = shift_rows(sub_bytes(st_r));
    dec_sb_s  = inv_sub_bytes(inv_shift_rows(st_r));
    dec_add_s = dec_sb_s ^ rk_s;
    if (mode_r) begin
      round_s = last_s ? dec_add_s : inv_mix_columns(dec_add_s);
    end else begin
      round_s = (last_s ? enc_sr_s : mix_columns(enc_sr_s)) ^ rk_s;
    end
  end

  // Next-state and next-output logic for the IDLE/RUN controller
  always_comb begin
    nxt_state_s    = state_r;
    nxt_rc_s       = rc_r;
    nxt_nr_s       = nr_r;
    nxt_mode_s     = mode_r;
    nxt_st_s       = st_r;
    nxt_data_out_s = data_out_r;
    nxt_busy_s     = busy_r;
    nxt_done_s     = 1'b0;
    nxt_err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && !abort_s) begin
          if (bus.key_len == 2'b11) begin
            nxt_err_s = 1'b1;
          end else begin
            nxt_state_s = RUN;
            nxt_busy_s  = 1'b1;
            nxt_rc_s    = RC_W'(1);
            nxt_nr_s    = acc_nr_s;
            nxt_mode_s  = bus.mode;
            nxt_st_s    = acc_st_s;
          end
        end else begin
          nxt_state_s = IDLE;
        end
      end
      RUN: begin
        if (abort_s) begin
          nxt_state_s = IDLE;
          nxt_busy_s  = 1'b0;
          nxt_rc_s    = RC_W'(0);
        end else if (last_s) begin
          nxt_state_s    = IDLE;
          nxt_busy_s     = 1'b0;
          nxt_done_s     = 1'b1;
          nxt_rc_s       = RC_W'(0);
          nxt_data_out_s = round_s;
        end else begin
          nxt_st_s = round_s;
          nxt_rc_s = rc_r + RC_W'(1);
        end
      end
      default: begin
        nxt_state_s = IDLE;
        nxt_busy_s  = 1'b0;
        nxt_rc_s    = RC_W'(0);
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rc_r       <= RC_W'(0);
      nr_r       <= RC_W'(10);
      mode_r     <= 1'b0;
      st_r       <= 128'h0;
      data_out_r <= 128'h0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      rc_r       <= nxt_rc_s;
      nr_r       <= nxt_nr_s;
      mode_r     <= nxt_mode_s;
      st_r       <= nxt_st_s;
      data_out_r <= nxt_data_out_s;
      busy_r     <= nxt_busy_s;
      done_r     <= nxt_done_s;
      err_r      <= nxt_err_s;
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed-vector bench for aes_iter_core using FIPS-197 known answers.
// Builds the expanded key schedules itself; AES_ABORT_EN enables the abort scenario.
module tb_aes_iter_core;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  aes_if #(.NR_MAX(14)) bus ();

  aes_iter_core #(.NR_MAX(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [1919:0] w128, w192, w256;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = ref_xtime(p);
    end
    return r;
  endfunction

  // S-box by exhaustive inverse search followed by the affine map
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (a != 8'h00 && ref_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   wd [0:59];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1919:0] ws;
    int            nw;
    nw   = 4 * (nk + 7);
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = ref_xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    ws = '0;
    for (int i = 0; i < nw; i++) ws[1919-32*i -: 32] = wd[i];
    return ws;
  endfunction

  // Advance edge by edge until done, giving up after 40 edges
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.done && edges < 40);
  endtask

  task automatic run_op(input string tag, input logic m, input logic [1:0] kl,
                        input logic [127:0] din, input logic [127:0] exp, input int lat);
    int edges;
    bus.mode    = m;
    bus.key_len = kl;
    bus.data_in = din;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, 128'(bus.busy), 128'd1);
    edges = 1;
    while (!bus.done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, 128'(edges), 128'(lat));
    check({tag, "_out"}, bus.data_out, exp);
    check({tag, "_idle"}, 128'(bus.busy), 128'd0);
  endtask

  initial begin
    int edges;
    int ndone;
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.key_len = 2'b00;
    bus.data_in = 128'h0;
`ifdef AES_ABORT_EN
    bus.abort   = 1'b0;
`endif
    w128  = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    w192  = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    w256  = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    bus.w = w128;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", bus.data_out, 128'h0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_err", 128'(bus.err), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("enc128", 1'b0, 2'b00, PT, CT128, 11);
    run_op("dec128", 1'b1, 2'b00, CT128, PT, 11);
    bus.w = w192;
    run_op("enc192", 1'b0, 2'b01, PT, CT192, 13);
    run_op("dec192", 1'b1, 2'b01, CT192, PT, 13);
    bus.w = w256;
    run_op("enc256", 1'b0, 2'b10, PT, CT256, 15);
    run_op("dec256", 1'b1, 2'b10, CT256, PT, 15);

    // Back-to-back: start held through the first done cycle
    bus.w       = w128;
    bus.mode    = 1'b1;
    bus.key_len = 2'b00;
    bus.data_in = CT128;
    bus.start   = 1'b1;
    wait_done(edges);
    check("b2b_lat1", 128'(edges), 128'd11);
    check("b2b_out1", bus.data_out, PT);
    bus.mode    = 1'b0;
    bus.data_in = PT;
    wait_done(edges);
    bus.start = 1'b0;
    check("b2b_gap", 128'(edges), 128'd11);
    check("b2b_out2", bus.data_out, CT128);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_stop", 128'(bus.busy), 128'd0);

    // Start pulses while busy produce no extra result
    bus.data_in = 128'hffeeddccbbaa99887766554433221100;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.data_in = PT;
    ndone       = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      bus.start = (cyc == 3 || cyc == 6);
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    check("pulse_ndone", 128'(ndone), 128'd1);
    check("pulse_idle", 128'(bus.busy), 128'd0);
    bus.data_in = PT;
    run_op("enc128b", 1'b0, 2'b00, PT, CT128, 11);

    // Illegal key length
    bus.key_len = 2'b11;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("err_pulse", 128'(bus.err), 128'd1);
    check("err_busy", 128'(bus.busy), 128'd0);
    check("err_done", 128'(bus.done), 128'd0);
    check("err_out", bus.data_out, CT128);
    @(posedge clk);
    #1;
    check("err_clear", 128'(bus.err), 128'd0);
    check("err_idle", 128'(bus.busy), 128'd0);

`ifdef AES_ABORT_EN
    bus.key_len = 2'b00;
    bus.mode    = 1'b1;
    bus.data_in = CT128;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_out", bus.data_out, CT128);
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("abort_ndone", 128'(ndone), 128'd0);
    check("abort_out2", bus.data_out, CT128);
`endif

    // Reset in the middle of an operation
    bus.key_len = 2'b00;
    bus.mode    = 1'b0;
    bus.data_in = PT;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", bus.data_out, 128'h0);
    check("mid_rst_busy", 128'(bus.busy), 128'd0);
    check("mid_rst_done", 128'(bus.done), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("mid_rst_ndone", 128'(ndone), 128'd0);
    check("mid_rst_out2", bus.data_out, 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
